// File: rtl/led_pattern_engine_if.sv
// LED pattern engine control/status bundle.
// The single-step request line exists only when LED_PATTERN_SINGLE_STEP_EN is defined.
// Direction convention: master = board logic driving tick/pause/mode,
// slave = the pattern engine producing leds/cur_mode and the event pulses.
// There is no valid/ready handshake here: inputs are sampled level signals
// and the two pulse outputs are single-cycle strobes.
interface led_pattern_engine_if #(
    parameter int WIDTH = 8
);
    logic             tick;
    logic             pause;
    logic [1:0]       mode;
`ifdef LED_PATTERN_SINGLE_STEP_EN
    logic             step_req;
`endif
    logic [WIDTH-1:0] leds;
    logic [1:0]       cur_mode;
    logic             step_pulse;
    logic             wrap_pulse;

    modport master (
`ifdef LED_PATTERN_SINGLE_STEP_EN
        output step_req,
`endif
        output tick,
        output pause,
        output mode,
        input  leds,
        input  cur_mode,
        input  step_pulse,
        input  wrap_pulse
    );

    modport slave (
`ifdef LED_PATTERN_SINGLE_STEP_EN
        input  step_req,
`endif
        input  tick,
        input  pause,
        input  mode,
        output leds,
        output cur_mode,
        output step_pulse,
        output wrap_pulse
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: drives a WIDTH-bit LED bank with one of four run-time
// selectable patterns (CHASE_L, CHASE_R, BOUNCE, FILL), advancing one step
// every DIV rising edges of the tick timebase.
// Optional feature macro: LED_PATTERN_SINGLE_STEP_EN adds a step_req input that
// advances exactly one step while paused.
// The interface instance must be built with the same WIDTH as this module.
module led_pattern_engine #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pattern_engine_if.slave  bus
);

    // Prescaler needs at least one bit even when DIV == 1 (it then stays at 0).
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    localparam logic [1:0] MODE_CHASE_L = 2'd0;
    localparam logic [1:0] MODE_CHASE_R = 2'd1;
    localparam logic [1:0] MODE_BOUNCE  = 2'd2;
    localparam logic [1:0] MODE_FILL    = 2'd3;

    localparam logic [WIDTH-1:0] LEDS_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LEDS_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LEDS_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LEDS_ZERO = {WIDTH{1'b0}};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Value the LEDs take when a mode is (re)entered; also the wrap target.
    function automatic logic [WIDTH-1:0] start_value(input logic [1:0] m);
        logic [WIDTH-1:0] v;
        case (m)
            MODE_CHASE_L: v = LEDS_LSB;
            MODE_CHASE_R: v = LEDS_MSB;
            MODE_BOUNCE:  v = LEDS_LSB;
            MODE_FILL:    v = LEDS_ZERO;
            default:      v = LEDS_LSB;
        endcase
        return v;
    endfunction

    logic [WIDTH-1:0] leds_q, leds_d;
    logic [1:0]       cur_mode_q, cur_mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    dir_e             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             step_pulse_q, step_pulse_d;
    logic             wrap_pulse_q, wrap_pulse_d;

    logic [WIDTH-1:0] nxt_leds;
    dir_e             nxt_dir;
    logic             tick_ev;
    logic             mode_chg;
    logic             presc_wrap;
    logic             tick_adv;
    logic             step_adv;

    // Next pattern value and bounce direction for one advance in the running mode.
    always_comb begin
        nxt_leds = leds_q;
        nxt_dir  = dir_q;
        case (cur_mode_q)
            MODE_CHASE_L: nxt_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
            MODE_CHASE_R: nxt_leds = {leds_q[0], leds_q[WIDTH-1:1]};
            MODE_BOUNCE: begin
                // Direction flips when the lit bit lands on an end, so the end
                // positions are shown once per pass.
                if (dir_q == DIR_UP) begin
                    nxt_leds = {leds_q[WIDTH-2:0], 1'b0};
                    if (nxt_leds[WIDTH-1]) begin
                        nxt_dir = DIR_DOWN;
                    end
                end else begin
                    nxt_leds = {1'b0, leds_q[WIDTH-1:1]};
                    if (nxt_leds[0]) begin
                        nxt_dir = DIR_UP;
                    end
                end
            end
            MODE_FILL: begin
                if (leds_q == LEDS_ONES) begin
                    nxt_leds = LEDS_ZERO;
                end else begin
                    nxt_leds = {leds_q[WIDTH-2:0], 1'b1};
                end
            end
            default: nxt_leds = leds_q;
        endcase
    end

    // Event decode: tick rising edge, mode change request, and advance sources.
    always_comb begin
        tick_ev    = bus.tick & ~tick_q;
        mode_chg   = (bus.mode != cur_mode_q);
        presc_wrap = (presc_q == PRESC_MAX);
        tick_adv   = tick_ev & ~bus.pause & presc_wrap;
`ifdef LED_PATTERN_SINGLE_STEP_EN
        step_adv   = bus.step_req & bus.pause;
`else
        step_adv   = 1'b0;
`endif
    end

    // Next-state: a mode change overrides any same-cycle advance; the tick
    // edge detector always tracks the input so releasing pause is harmless.
    always_comb begin
        leds_d       = leds_q;
        cur_mode_d   = cur_mode_q;
        presc_d      = presc_q;
        dir_d        = dir_q;
        tick_d       = bus.tick;
        step_pulse_d = 1'b0;
        wrap_pulse_d = 1'b0;
        if (mode_chg) begin
            cur_mode_d = bus.mode;
            leds_d     = start_value(bus.mode);
            presc_d    = '0;
            dir_d      = DIR_UP;
        end else begin
            if (tick_ev && !bus.pause) begin
                presc_d = presc_wrap ? '0 : presc_q + PW'(1);
            end
            if (tick_adv || step_adv) begin
                leds_d       = nxt_leds;
                dir_d        = nxt_dir;
                step_pulse_d = 1'b1;
                wrap_pulse_d = (nxt_leds == start_value(cur_mode_q));
            end
        end
    end

    // State registers with asynchronous reset to CHASE_L start state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q       <= LEDS_LSB;
            cur_mode_q   <= MODE_CHASE_L;
            presc_q      <= '0;
            dir_q        <= DIR_UP;
            tick_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            leds_q       <= leds_d;
            cur_mode_q   <= cur_mode_d;
            presc_q      <= presc_d;
            dir_q        <= dir_d;
            tick_q       <= tick_d;
            step_pulse_q <= step_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign bus.leds       = leds_q;
    assign bus.cur_mode   = cur_mode_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: one DIV=1 instance for pattern,
// mode and pause behaviour, one DIV=3 instance for the prescaler.
// Define LED_PATTERN_SINGLE_STEP_EN to also exercise single stepping.
module tb_led_pattern_engine;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_pattern_engine_if #(.WIDTH(8)) if1 ();
    led_pattern_engine_if #(.WIDTH(8)) if3 ();

    led_pattern_engine #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    led_pattern_engine #(.WIDTH(8), .DIV(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    // Driver tasks: all start and end on a falling clock edge.
    task automatic tick1_rise();
        if1.tick = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick1_fall();
        if1.tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick3_rise();
        if3.tick = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick3_fall();
        if3.tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h01) begin
            errors++;
            $display("FAIL reset_leds: got %h expected 01", if1.leds);
        end
        checks++;
        if (if1.cur_mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_cur_mode: got %0d expected 0", if1.cur_mode);
        end
        checks++;
        if (if1.step_pulse !== 1'b0 || if1.wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got step=%b wrap=%b expected 0 0", if1.step_pulse, if1.wrap_pulse);
        end
        checks++;
        if (if3.leds !== 8'h01) begin
            errors++;
            $display("FAIL reset_leds_div3: got %h expected 01", if3.leds);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_chase_left();
        logic [7:0] exp;
        for (int i = 1; i <= 9; i++) begin
            exp = 8'(1 << (i % 8));
            tick1_rise();
            checks++;
            if (if1.leds !== exp) begin
                errors++;
                $display("FAIL chase_l_leds ev%0d: got %h expected %h", i, if1.leds, exp);
            end
            checks++;
            if (if1.step_pulse !== 1'b1) begin
                errors++;
                $display("FAIL chase_l_step ev%0d: got %b expected 1", i, if1.step_pulse);
            end
            checks++;
            if (if1.wrap_pulse !== (i == 8)) begin
                errors++;
                $display("FAIL chase_l_wrap ev%0d: got %b expected %b", i, if1.wrap_pulse, (i == 8));
            end
            tick1_fall();
            checks++;
            if (if1.step_pulse !== 1'b0) begin
                errors++;
                $display("FAIL chase_l_step_low ev%0d: got %b expected 0", i, if1.step_pulse);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp;
        int k;
        int pos;
        int wraps;
        wraps = 0;
        if1.mode = 2'd2;
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h01 || if1.cur_mode !== 2'd2 || if1.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL bounce_load: got leds=%h mode=%0d step=%b expected 01 2 0",
                     if1.leds, if1.cur_mode, if1.step_pulse);
        end
        for (int i = 1; i <= 15; i++) begin
            k   = i % 14;
            pos = (k <= 7) ? k : 14 - k;
            exp = 8'(1 << pos);
            tick1_rise();
            if (if1.wrap_pulse === 1'b1) wraps++;
            checks++;
            if (if1.leds !== exp || if1.step_pulse !== 1'b1) begin
                errors++;
                $display("FAIL bounce_step ev%0d: got leds=%h step=%b expected %h 1",
                         i, if1.leds, if1.step_pulse, exp);
            end
            checks++;
            if (if1.wrap_pulse !== (k == 0)) begin
                errors++;
                $display("FAIL bounce_wrap ev%0d: got %b expected %b", i, if1.wrap_pulse, (k == 0));
            end
            tick1_fall();
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL bounce_wrap_count: got %0d expected 1", wraps);
        end
    endtask

    task automatic test_fill_and_mode_change();
        logic [7:0] exp;
        if1.mode = 2'd3;
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h00 || if1.cur_mode !== 2'd3) begin
            errors++;
            $display("FAIL fill_load: got leds=%h mode=%0d expected 00 3", if1.leds, if1.cur_mode);
        end
        for (int i = 1; i <= 9; i++) begin
            exp = (i == 9) ? 8'h00 : 8'((1 << i) - 1);
            tick1_rise();
            checks++;
            if (if1.leds !== exp || if1.step_pulse !== 1'b1 || if1.wrap_pulse !== (i == 9)) begin
                errors++;
                $display("FAIL fill_step ev%0d: got leds=%h step=%b wrap=%b expected %h 1 %b",
                         i, if1.leds, if1.step_pulse, if1.wrap_pulse, exp, (i == 9));
            end
            tick1_fall();
        end
        for (int i = 0; i < 3; i++) begin
            tick1_rise();
            tick1_fall();
        end
        checks++;
        if (if1.leds !== 8'h07) begin
            errors++;
            $display("FAIL fill_midrun: got %h expected 07", if1.leds);
        end
        if1.mode = 2'd1;
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h80 || if1.cur_mode !== 2'd1 || if1.step_pulse !== 1'b0 || if1.wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mode_change_midrun: got leds=%h mode=%0d step=%b wrap=%b expected 80 1 0 0",
                     if1.leds, if1.cur_mode, if1.step_pulse, if1.wrap_pulse);
        end
        // Mode change and tick event on the same edge: the event is discarded.
        if1.mode = 2'd0;
        tick1_rise();
        checks++;
        if (if1.leds !== 8'h01 || if1.cur_mode !== 2'd0 || if1.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mode_vs_tick: got leds=%h mode=%0d step=%b expected 01 0 0",
                     if1.leds, if1.cur_mode, if1.step_pulse);
        end
        tick1_fall();
        tick1_rise();
        checks++;
        if (if1.leds !== 8'h02 || if1.step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL after_mode_vs_tick: got leds=%h step=%b expected 02 1", if1.leds, if1.step_pulse);
        end
        tick1_fall();
    endtask

    task automatic test_prescaler_pause();
        logic [7:0] exp;
        for (int i = 1; i <= 8; i++) begin
            exp = (i < 3) ? 8'h01 : (i < 6) ? 8'h02 : 8'h04;
            tick3_rise();
            checks++;
            if (if3.leds !== exp || if3.step_pulse !== (i % 3 == 0)) begin
                errors++;
                $display("FAIL presc_ev%0d: got leds=%h step=%b expected %h %b",
                         i, if3.leds, if3.step_pulse, exp, (i % 3 == 0));
            end
            tick3_fall();
        end
        // Prescaler now holds 2; pause across five tick periods.
        if3.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick3_rise();
            checks++;
            if (if3.leds !== 8'h04 || if3.step_pulse !== 1'b0) begin
                errors++;
                $display("FAIL presc_paused p%0d: got leds=%h step=%b expected 04 0", i, if3.leds, if3.step_pulse);
            end
            tick3_fall();
        end
        if3.pause = 1'b0;
        @(negedge clk);
        tick3_rise();
        checks++;
        if (if3.leds !== 8'h08 || if3.step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL presc_resume: got leds=%h step=%b expected 08 1", if3.leds, if3.step_pulse);
        end
        tick3_fall();
    endtask

    task automatic test_pause_release_and_reset();
        if1.pause = 1'b1;
        tick1_rise();
        checks++;
        if (if1.leds !== 8'h02 || if1.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pause_edge: got leds=%h step=%b expected 02 0", if1.leds, if1.step_pulse);
        end
        if1.pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h02 || if1.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pause_release_high: got leds=%h step=%b expected 02 0", if1.leds, if1.step_pulse);
        end
        tick1_fall();
        tick1_rise();
        checks++;
        if (if1.leds !== 8'h04 || if1.step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL after_release: got leds=%h step=%b expected 04 1", if1.leds, if1.step_pulse);
        end
        tick1_fall();
        if1.mode = 2'd2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tick1_rise();
            tick1_fall();
        end
        checks++;
        if (if1.leds !== 8'h10 || if1.cur_mode !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset: got leds=%h mode=%0d expected 10 2", if1.leds, if1.cur_mode);
        end
        // Assert reset away from any clock edge; outputs must clear immediately.
        #2;
        reset     = 1'b1;
        if1.mode  = 2'd0;
        #1;
        checks++;
        if (if1.leds !== 8'h01 || if1.cur_mode !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got leds=%h mode=%0d expected 01 0", if1.leds, if1.cur_mode);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h01 || if1.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got leds=%h step=%b expected 01 0", if1.leds, if1.step_pulse);
        end
    endtask

`ifdef LED_PATTERN_SINGLE_STEP_EN
    task automatic test_single_step();
        logic [7:0] exp;
        if1.pause = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            exp = 8'(1 << i);
            if1.step_req = 1'b1;
            @(negedge clk);
            checks++;
            if (if1.leds !== exp || if1.step_pulse !== 1'b1) begin
                errors++;
                $display("FAIL single_step s%0d: got leds=%h step=%b expected %h 1", i, if1.leds, if1.step_pulse, exp);
            end
            if1.step_req = 1'b0;
            @(negedge clk);
        end
        if1.pause    = 1'b0;
        if1.step_req = 1'b1;
        @(negedge clk);
        if1.step_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h04) begin
            errors++;
            $display("FAIL step_unpaused: got leds=%h expected 04", if1.leds);
        end
        if1.pause    = 1'b1;
        if1.mode     = 2'd1;
        if1.step_req = 1'b1;
        @(negedge clk);
        checks++;
        if (if1.leds !== 8'h80 || if1.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL step_vs_mode: got leds=%h step=%b expected 80 0", if1.leds, if1.step_pulse);
        end
        if1.step_req = 1'b0;
        if1.pause    = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        if1.tick  = 1'b0;
        if1.pause = 1'b0;
        if1.mode  = 2'd0;
        if3.tick  = 1'b0;
        if3.pause = 1'b0;
        if3.mode  = 2'd0;
`ifdef LED_PATTERN_SINGLE_STEP_EN
        if1.step_req = 1'b0;
        if3.step_req = 1'b0;
`endif
        test_reset();
        test_chase_left();
        test_bounce();
        test_fill_and_mode_change();
        test_prescaler_pause();
        test_pause_release_and_reset();
`ifdef LED_PATTERN_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
